btime_input_cond: RTL

//  Player input conditioner that sits between the hps_io joystick words and the burger_time core inputs.
//  - Synchronises the raw joystick_0/joystick_1 words and debounces the coin and start buttons.
//  - Turns each coin press into exactly one fixed-width coin pulse followed by a minimum gap, and counts accepted coins.
//  - Also drives the direction, fire and pause inputs consumed by the core and the pause block.

---
 rtl/btime_input_cond.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/btime_input_cond.sv
// btime_input_cond: joystick sync, coin/start debounce, coin pulse shaping.
// Optional BTIME_COIN_LOCKOUT_EN adds a synchronised coin_lockout input.
module btime_input_cond #(
  parameter int DEBOUNCE_CYCLES   = 12000,
  parameter int COIN_PULSE_CYCLES = 600000,
  parameter int COIN_GAP_CYCLES   = 600000,
  parameter int CNT_W             = 20
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [15:0] joystick_0,
  input  logic [15:0] joystick_1,
  input  logic        pause_cpu,
`ifdef BTIME_COIN_LOCKOUT_EN
  input  logic        coin_lockout,
`endif
  output logic        up1,
  output logic        down1,
  output logic        left1,
  output logic        right1,
  output logic        fire1,
  output logic        up2,
  output logic        down2,
  output logic        left2,
  output logic        right2,
  output logic        fire2,
  output logic        start1,
  output logic        start2,
  output logic        coin1,
  output logic        coin2,
  output logic        pause_btn,
  output logic [7:0]  coin_count
);

  typedef enum logic [1:0] {
    IDLE,
    PULSE,
    GAP,
    WAIT_REL
  } coin_st_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] PL_LAST = CNT_W'(COIN_PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GP_LAST = CNT_W'(COIN_GAP_CYCLES - 1);

  logic [17:0]      s1_q, s1_d, s2_q, s2_d;
  logic [8:0]       or_w;
  logic [3:0]       lvl, deb_q, deb_d, rise;
  logic [CNT_W-1:0] dcnt_q [4];
  logic [CNT_W-1:0] dcnt_d [4];
  coin_st_e         st_q [2];
  coin_st_e         st_d [2];
  logic [CNT_W-1:0] tmr_q [2];
  logic [CNT_W-1:0] tmr_d [2];
  logic [1:0]       pend_q, pend_d;
  logic [1:0]       coin_q, coin_d;
  logic [1:0]       acc, c_rise, c_deb;
  logic [7:0]       cnt_q, cnt_d;
  logic             lock;
  logic             unused_bits;

  assign unused_bits = ^{joystick_0[15:9], joystick_1[15:9], rise[1:0]};

`ifdef BTIME_COIN_LOCKOUT_EN
  logic [1:0] lk_q, lk_d;

  // two-flop synchroniser for the lockout request
  always_comb lk_d = {lk_q[0], coin_lockout};

  // lockout sync flops
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) lk_q <= '0;
    else       lk_q <= lk_d;
  end

  assign lock = lk_q[1];
`else
  assign lock = 1'b0;
`endif

  // the two player words are merged only after synchronising
  assign or_w = s2_q[8:0] | s2_q[17:9];
  // debounced signals: start1, start2, coin_a (j0), coin_b (j1)
  assign lvl  = {s2_q[16], s2_q[7], or_w[6], or_w[5]};

  // sync pipeline, debouncers and coin state machines
  always_comb begin
    s1_d = {joystick_1[8:0], joystick_0[8:0]};
    s2_d = s1_q;
    deb_d = deb_q;
    rise = '0;
    for (int i = 0; i < 4; i++) begin
      dcnt_d[i] = '0;
      if (lvl[i] != deb_q[i]) begin
        if (dcnt_q[i] == DB_LAST) begin
          deb_d[i] = lvl[i];
          rise[i] = lvl[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
    c_rise = rise[3:2];
    c_deb = deb_q[3:2];
    pend_d = pend_q;
    coin_d = coin_q;
    acc = '0;
    for (int c = 0; c < 2; c++) begin
      st_d[c] = st_q[c];
      tmr_d[c] = tmr_q[c];
      unique case (st_q[c])
        IDLE: begin
          if (!lock && c_rise[c] && pause_cpu) pend_d[c] = 1'b1;
          if (!lock && !pause_cpu && (c_rise[c] || pend_q[c])) begin
            acc[c] = 1'b1;
            pend_d[c] = 1'b0;
            coin_d[c] = 1'b1;
            tmr_d[c] = '0;
            st_d[c] = PULSE;
          end
        end
        PULSE: begin
          if (tmr_q[c] == PL_LAST) begin
            coin_d[c] = 1'b0;
            tmr_d[c] = '0;
            st_d[c] = GAP;
          end else begin
            tmr_d[c] = tmr_q[c] + 1'b1;
          end
        end
        GAP: begin
          if (tmr_q[c] == GP_LAST) begin
            tmr_d[c] = '0;
            st_d[c] = c_deb[c] ? WAIT_REL : IDLE;
          end else begin
            tmr_d[c] = tmr_q[c] + 1'b1;
          end
        end
        WAIT_REL: begin
          if (!c_deb[c]) st_d[c] = IDLE;
        end
      endcase
    end
    cnt_d = cnt_q + 8'(acc[0]) + 8'(acc[1]);
  end

  // all state flops; reset drops the coin outputs immediately
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      deb_q  <= '0;
      dcnt_q <= '{default: '0};
      st_q   <= '{default: IDLE};
      tmr_q  <= '{default: '0};
      pend_q <= '0;
      coin_q <= '0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      deb_q  <= deb_d;
      dcnt_q <= dcnt_d;
      st_q   <= st_d;
      tmr_q  <= tmr_d;
      pend_q <= pend_d;
      coin_q <= coin_d;
      cnt_q  <= cnt_d;
    end
  end

  assign up1        = or_w[3];
  assign down1      = or_w[2];
  assign left1      = or_w[1];
  assign right1     = or_w[0];
  assign fire1      = or_w[4];
  assign up2        = or_w[3];
  assign down2      = or_w[2];
  assign left2      = or_w[1];
  assign right2     = or_w[0];
  assign fire2      = or_w[4];
  assign pause_btn  = or_w[8];
  assign start1     = deb_q[0];
  assign start2     = deb_q[1];
  assign coin1      = coin_q[0];
  assign coin2      = coin_q[1];
  assign coin_count = cnt_q;

endmodule
